// File: rtl/rr_flit_arbiter_pkg.sv
// Shared router definitions: default sizing, flit type and arbiter state enum.
package rr_flit_arbiter_pkg;

  localparam int N_IN_DEF   = 5;
  localparam int FLIT_W_DEF = 32;

  typedef logic [FLIT_W_DEF-1:0] flit_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_flit_arbiter_pick.sv
// Rotating-priority first-valid finder: searches req starting at ptr and
// wrapping around, returns whether any request exists and the first index.
module rr_pick #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // One extra bit so ptr + offset never overflows before the wrap subtract.
  logic [IDX_W:0] cand;

  // Walk offsets 0..N-1 from ptr; the first requesting candidate wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_flit_arbiter.sv
// Round-robin flit arbiter with packet locking. A head flit from the winning
// channel locks the output to that channel until its tail flit passes.
// Handshake: a flit moves on a side when valid and ready are both high at a
// rising clk edge; in_ready may depend on in_valid and out_ready, and at most
// one in_ready bit is high in any cycle.
module rr_flit_arbiter
  import rr_flit_arbiter_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_IN-1:0]               in_valid,
  input  logic [N_IN-1:0]               in_last,
  input  logic [N_IN-1:0][FLIT_W-1:0]   in_data,
  output logic [N_IN-1:0]               in_ready,
  output logic                          out_valid,
  output logic                          out_last,
  output logic [FLIT_W-1:0]             out_data,
  input  logic                          out_ready,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          locked,
  output arb_state_e                    dbg_state,
  output logic [IDX_W-1:0]              dbg_ptr
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] sel;
  logic             active;
  logic             xfer;

  // Channel after v, wrapping N_IN-1 back to 0 so ptr never holds >= N_IN.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    if (v == IDX_W'(N_IN-1)) return '0;
    return v + IDX_W'(1);
  endfunction

  rr_pick #(
    .N     (N_IN),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (in_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Select the channel driving the output: the owner when locked, else the
  // round-robin winner, else park on ptr.
  always_comb begin
    sel    = ptr_q;
    active = 1'b0;
    if (state_q == ST_LOCKED) begin
      sel    = owner_q;
      active = in_valid[owner_q];
    end else if (pick_found) begin
      sel    = pick_idx;
      active = 1'b1;
    end
  end

  assign xfer = active & out_ready;

  // Output mux and ready steering; everything is quiet while reset is held.
  always_comb begin
    out_valid = rst_n & active;
    out_last  = rst_n & active & in_last[sel];
    out_data  = in_data[sel];
    grant_idx = rst_n ? sel : '0;
    in_ready  = '0;
    if (rst_n && ((state_q == ST_LOCKED) || pick_found)) in_ready[sel] = out_ready;
    locked    = (state_q == ST_LOCKED);
    dbg_state = state_q;
    dbg_ptr   = ptr_q;
  end

  // Next-state: head flit locks, tail flit unlocks and advances the pointer.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (in_last[sel]) begin
            ptr_d = wrap_inc(sel);
          end else begin
            state_d = ST_LOCKED;
            owner_d = sel;
          end
        end
      end
      ST_LOCKED: begin
        if (xfer && in_last[sel]) begin
          state_d = ST_IDLE;
          ptr_d   = wrap_inc(owner_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any packet and restarts at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_rr_flit_arbiter.sv
// Randomized bench for rr_flit_arbiter against a packet-level round-robin model.
module tb_rr_flit_arbiter;
  import rr_flit_arbiter_pkg::*;

  localparam int N  = 5;
  localparam int W  = 32;
  localparam int IW = 3;
  localparam int N_ITER = 2000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]        in_valid, in_last, in_ready;
  logic [N-1:0][W-1:0] in_data;
  logic                out_valid, out_last, out_ready;
  logic [W-1:0]        out_data;
  logic [IW-1:0]       grant_idx, dbg_ptr;
  logic                locked;
  arb_state_e          dbg_state;

  rr_flit_arbiter #(.N_IN(N), .FLIT_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_idx (grant_idx),
    .locked    (locked),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- sources ----------------
  int src_left[N];   // flits left in current packet (0 = no packet)
  bit src_first[N];  // next flit shown is a head flit
  int wait_pk[N];    // other packets completed while this head flit waited

  // ---------------- reference model ----------------
  bit m_locked;
  int m_owner;
  int m_ptr;
  logic [W:0] exp_q[$];

  task automatic model_reset();
    m_locked = 0;
    m_owner  = 0;
    m_ptr    = 0;
    exp_q.delete();
    for (int c = 0; c < N; c++) begin
      src_left[c]  = 0;
      src_first[c] = 1;
      wait_pk[c]   = 0;
    end
    in_valid = '0;
    in_last  = '0;
  endtask

  // Present new flits on idle channels and pick a random out_ready.
  task automatic drive_sources();
    for (int c = 0; c < N; c++) begin
      if (!in_valid[c]) begin
        if (src_left[c] == 0 && $urandom_range(0, 2) == 0) begin
          src_left[c]  = $urandom_range(1, 4);
          src_first[c] = 1;
        end
        if (src_left[c] > 0 && $urandom_range(0, 3) != 0) begin
          in_valid[c] = 1'b1;
          in_last[c]  = (src_left[c] == 1);
          in_data[c]  = $urandom;
        end
      end
    end
    out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Retire the flit accepted at the last edge.
  task automatic consume(input int c);
    if (c >= 0) begin
      in_valid[c]  = 1'b0;
      in_last[c]   = 1'b0;
      src_left[c]  = src_left[c] - 1;
      src_first[c] = (src_left[c] == 0);
    end
  endtask

  // Compare DUT outputs with the model for this cycle and advance the model.
  task automatic check_cycle(output int took);
    int g;
    bit ov;
    logic [N-1:0] er;
    g  = m_ptr;
    ov = 0;
    er = '0;
    took = -1;
    if (m_locked) begin
      g  = m_owner;
      ov = in_valid[m_owner];
      er[m_owner] = out_ready;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!ov && in_valid[(m_ptr + k) % N]) begin
          g  = (m_ptr + k) % N;
          ov = 1;
        end
      end
      if (ov) er[g] = out_ready;
    end

    chk("out_valid", out_valid, ov);
    chk("grant_idx", grant_idx, g);
    chk("in_ready", in_ready, er);
    chk("locked", locked, m_locked);
    chk("ptr", dbg_ptr, m_ptr);
    if (ov) begin
      chk("out_data", out_data, in_data[g]);
      chk("out_last", out_last, in_last[g]);
    end

    // scoreboard: the input-side handshake must reappear at the output
    for (int c = 0; c < N; c++) begin
      if (in_valid[c] && in_ready[c]) begin
        exp_q.push_back({in_last[c], in_data[c]});
        took = c;
        if (src_first[c]) begin
          chk("fairness", (wait_pk[c] <= N - 1), 1);
          wait_pk[c] = 0;
        end
      end
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
      else chk("sb_flit", {out_last, out_data}, exp_q.pop_front());
    end

    // model state advance
    if (ov && out_ready) begin
      if (in_last[g]) begin
        for (int c = 0; c < N; c++)
          if (c != g && in_valid[c] && src_first[c]) wait_pk[c]++;
        m_locked = 0;
        m_ptr    = (g + 1) % N;
      end else if (!m_locked) begin
        m_locked = 1;
        m_owner  = g;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_in_ready"}, in_ready, '0);
    chk({tag, "_locked"}, locked, 1'b0);
    chk({tag, "_grant"}, grant_idx, '0);
    chk({tag, "_ptr"}, dbg_ptr, '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int took;
    int n_rst;
    took     = -1;
    n_rst    = 0;
    in_data  = '0;
    out_ready = 1'b1;
    model_reset();

    // Reset with requests present: outputs must stay quiet.
    #2;
    in_valid = 5'b10110;
    in_last  = '1;
    #1;
    check_reset_outputs("rst_init");
    in_valid = '0;
    in_last  = '0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int it = 0; it < N_ITER; it++) begin
      @(posedge clk);
      #1;
      consume(took);
      drive_sources();
      #3;
      check_cycle(took);
      // Pulse reset mid-packet a couple of times.
      if (m_locked && ((n_rst == 0 && it > 500) || (n_rst == 1 && it > 1300))) begin
        n_rst++;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        model_reset();
        took = -1;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    chk("reset_pulses", n_rst, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
